// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: framed by i_start, one bit per i_sample,
// completed words parked in a valid/ready holding register.
module shift_deser #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CW        = $clog2(N + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_start,
  input  logic          i_sample,
  input  logic          i_sdata,
  input  logic          i_ready,
  output logic [N-1:0]  o_data,
  output logic          o_valid,
  output logic          o_busy,
  output logic          o_overrun,
  output logic [CW-1:0] o_bit_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state     = IDLE;
  logic [CW-1:0] bit_cnt   = '0;
  logic [N-1:0]  sr        = '0;
  logic [N-1:0]  data_q    = '0;
  logic          valid_q   = 1'b0;
  logic          overrun_q = 1'b0;

  state_t        state_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [N-1:0]  sr_nxt;
  logic [N-1:0]  shifted;
  logic          done;
  logic          last_bit;

  assign last_bit = (bit_cnt == CW'(N - 1));

  always_comb begin
    if (LSB_FIRST) shifted = {i_sdata, sr[N-1:1]};
    else           shifted = {sr[N-2:0], i_sdata};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    sr_nxt    = sr;
    done      = 1'b0;
    if (i_ce) begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
            sr_nxt    = '0;
          end
        end
        SHIFT: begin
          if (i_start) begin
            cnt_nxt = '0;
            sr_nxt  = '0;
          end else if (i_sample) begin
            sr_nxt = shifted;
            if (last_bit) begin
              done      = 1'b1;
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (i_ce) begin
        state   <= state_nxt;
        bit_cnt <= cnt_nxt;
        sr      <= sr_nxt;
      end
      // The handshake runs off the free clock, independent of i_ce.
      if (done) begin
        if (!valid_q || i_ready) begin
          data_q  <= shifted;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = (state == SHIFT);
  assign o_overrun = overrun_q;
  assign o_bit_cnt = bit_cnt;

endmodule
